// File: rtl/conv_window_sequencer_pkg.sv
// Shared definitions for the convolution window sequencer: FSM state encoding
// and the output-dimension helper used for the elaboration-time geometry check.
package conv_window_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } conv_state_t;

  function automatic int conv_out_dim(input int in_dim, input int k, input int pad, input int s);
    return (in_dim + 2 * pad - k) / s + 1;
  endfunction

endpackage

// File: rtl/conv_window_sequencer_anchor.sv
// 2-D output-grid counter: column advances first, wraps into the next row.
// Anchors are the zero-extended counters scaled by the stride.
module conv_anchor_counter #(
  parameter int data_width    = 16,
  parameter int result_length = 2,
  parameter int result_width  = 2,
  parameter int stride        = 1,
  parameter int slot_w        = ((result_length * result_width) > 1) ? $clog2(result_length * result_width) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  step,
  output logic [data_width-1:0] anchor_2d,
  output logic [data_width-1:0] anchor_1d,
  output logic [slot_w-1:0]     slot,
  output logic                  last
);

  localparam int r_w = (result_length > 1) ? $clog2(result_length) : 1;
  localparam int c_w = (result_width > 1) ? $clog2(result_width) : 1;

  logic [r_w-1:0] r;
  logic [c_w-1:0] c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r <= '0;
      c <= '0;
    end else if (clear) begin
      r <= '0;
      c <= '0;
    end else if (step) begin
      if (c == c_w'(result_width - 1)) begin
        c <= '0;
        r <= r + 1'b1;
      end else begin
        c <= c + 1'b1;
      end
    end
  end

  assign anchor_2d = data_width'(32'(r) * stride);
  assign anchor_1d = data_width'(32'(c) * stride);
  assign slot      = slot_w'(32'(r) * result_width + 32'(c));
  assign last      = (r == r_w'(result_length - 1)) && (c == c_w'(result_width - 1));

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks the output grid, hands each window to the MAC and packs the returned
// float16 sums into the result map (slot 0 at the MSB end).
module conv_window_sequencer
  import conv_window_sequencer_pkg::*;
#(
  parameter int data_width    = 16,
  parameter int image_length  = 4,
  parameter int image_width   = 4,
  parameter int weight_length = 3,
  parameter int weight_width  = 3,
  parameter int result_length = 2,
  parameter int result_width  = 2,
  parameter int stride        = 1,
  parameter int padding_en    = 0,
  parameter int padding       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  conv_en,
  output logic [data_width-1:0] archor_2D,
  output logic [data_width-1:0] archor_1D,
  output logic                  win_valid,
  input  logic                  win_ready,
  input  logic                  res_valid,
  input  logic [data_width-1:0] res_data,
  output logic [0:result_length*result_width*data_width-1] result,
  output logic                  busy,
  output logic                  conv_done
);

  localparam int n_slots = result_length * result_width;
  localparam int slot_w  = (n_slots > 1) ? $clog2(n_slots) : 1;
  localparam int pad_eff = padding * padding_en;

  if (result_length != conv_out_dim(image_length, weight_length, pad_eff, stride)) begin : g_bad_length
    $error("conv_window_sequencer: result_length does not match image/kernel/stride/padding");
  end
  if (result_width != conv_out_dim(image_width, weight_width, pad_eff, stride)) begin : g_bad_width
    $error("conv_window_sequencer: result_width does not match image/kernel/stride/padding");
  end

  conv_state_t       state, state_nxt;
  logic              conv_en_q;
  logic              start;
  logic              clear_cnt;
  logic              step_cnt;
  logic              wr_en;
  logic [slot_w-1:0] slot;
  logic              last_slot;

  conv_anchor_counter #(
    .data_width    (data_width),
    .result_length (result_length),
    .result_width  (result_width),
    .stride        (stride),
    .slot_w        (slot_w)
  ) u_anchor (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_cnt),
    .step      (step_cnt),
    .anchor_2d (archor_2D),
    .anchor_1d (archor_1D),
    .slot      (slot),
    .last      (last_slot)
  );

  assign start = conv_en && !conv_en_q && (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      conv_en_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      conv_en_q <= conv_en;
    end
  end

  // Abort (conv_en low) takes priority over a handshake or a result in the same cycle.
  always_comb begin
    state_nxt = state;
    clear_cnt = 1'b0;
    step_cnt  = 1'b0;
    wr_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
          clear_cnt = 1'b1;
        end
      end
      SETTLE: state_nxt = conv_en ? ISSUE : IDLE;
      ISSUE: begin
        if (!conv_en)       state_nxt = IDLE;
        else if (win_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (!conv_en) begin
          state_nxt = IDLE;
        end else if (res_valid) begin
          wr_en = 1'b1;
          if (last_slot) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SETTLE;
            step_cnt  = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
    end else if (clear_cnt) begin
      result <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < n_slots; i++) begin
        if (slot == slot_w'(i)) result[i*data_width +: data_width] <= res_data;
      end
    end
  end

  assign win_valid = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign conv_done = (state == DONE);

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench: default 4x4/3x3 instance with a 3-cycle MAC model, plus a
// 5x5 stride-2 instance with a 1-cycle MAC model.
module tb_conv_window_sequencer;

  logic        clk;
  logic        reset;

  logic        conv_en;
  logic        win_ready;
  logic [15:0] archor_2D_a, archor_1D_a;
  logic        win_valid_a;
  logic        mac_rv, stray_rv;
  logic [15:0] mac_data, stray_data;
  logic        res_valid_a;
  logic [15:0] res_data_a;
  logic [0:63] result_a;
  logic        busy_a, conv_done_a;

  logic        conv_en_b;
  logic        win_ready_b;
  logic [15:0] archor_2D_b, archor_1D_b;
  logic        win_valid_b;
  logic        rv_b;
  logic [15:0] data_b;
  logic [0:63] result_b;
  logic        busy_b, conv_done_b;

  logic [15:0] mac_base, mac_step;
  int          mac_cnt;
  int          hs_cnt, hs_b, done_a, done_b;
  logic [15:0] log2d [0:63];
  logic [15:0] log1d [0:63];
  logic [15:0] logb2d [0:63];
  logic [15:0] logb1d [0:63];

  int checks, failures;

  assign res_valid_a = mac_rv | stray_rv;
  assign res_data_a  = stray_rv ? stray_data : mac_data;

  conv_window_sequencer u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .conv_en   (conv_en),
    .archor_2D (archor_2D_a),
    .archor_1D (archor_1D_a),
    .win_valid (win_valid_a),
    .win_ready (win_ready),
    .res_valid (res_valid_a),
    .res_data  (res_data_a),
    .result    (result_a),
    .busy      (busy_a),
    .conv_done (conv_done_a)
  );

  conv_window_sequencer #(
    .image_length (5),
    .image_width  (5),
    .stride       (2)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .conv_en   (conv_en_b),
    .archor_2D (archor_2D_b),
    .archor_1D (archor_1D_b),
    .win_valid (win_valid_b),
    .win_ready (win_ready_b),
    .res_valid (rv_b),
    .res_data  (data_b),
    .result    (result_b),
    .busy      (busy_b),
    .conv_done (conv_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC model A: answers 3 cycles after the handshake edge; sum encodes slot when mac_step != 0.
  always @(posedge clk) begin
    mac_rv <= 1'b0;
    if (mac_cnt != 0) begin
      mac_cnt <= mac_cnt - 1;
      if (mac_cnt == 1) mac_rv <= 1'b1;
    end
    if (win_valid_a && win_ready) begin
      log2d[hs_cnt[5:0]] <= archor_2D_a;
      log1d[hs_cnt[5:0]] <= archor_1D_a;
      hs_cnt   <= hs_cnt + 1;
      mac_cnt  <= 2;
      mac_data <= mac_base + mac_step * (archor_2D_a * 16'd2 + archor_1D_a);
    end
    if (conv_done_a) done_a <= done_a + 1;
  end

  // MAC model B: answers the cycle after the handshake.
  always @(posedge clk) begin
    rv_b <= win_valid_b;
    if (win_valid_b) begin
      logb2d[hs_b[5:0]] <= archor_2D_b;
      logb1d[hs_b[5:0]] <= archor_1D_b;
      hs_b   <= hs_b + 1;
      data_b <= 16'h3C00 + 16'(hs_b);
    end
    if (conv_done_b) done_b <= done_b + 1;
  end

  initial begin
    mac_cnt = 0; hs_cnt = 0; hs_b = 0; done_a = 0; done_b = 0;
    mac_rv = 1'b0; mac_data = 16'h0; rv_b = 1'b0; data_b = 16'h0;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done_a(input int budget, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (conv_done_a) begin
        ok = 1'b1;
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    bit          ok;
    int          cyc, h0, d0;
    logic        hold_ok;
    logic [15:0] s1;

    checks = 0; failures = 0;
    reset = 1'b0; conv_en = 1'b0; win_ready = 1'b1; conv_en_b = 1'b0; win_ready_b = 1'b1;
    stray_rv = 1'b0; stray_data = 16'h0; mac_base = 16'h4880; mac_step = 16'h0;
    tick(2);
    check_val("rst_busy",    64'(busy_a), 64'h0);
    check_val("rst_valid",   64'(win_valid_a), 64'h0);
    check_val("rst_anchor",  64'({archor_2D_a, archor_1D_a}), 64'h0);
    check_val("rst_result",  result_a, 64'h0);
    check_val("rst_done",    64'(conv_done_a), 64'h0);
    reset = 1'b1;
    tick(1);

    // 1: default geometry, constant 9.0 sums, 5-cycle windows
    h0 = hs_cnt;
    conv_en = 1'b1;
    wait_done_a(100, ok, cyc);
    check_val("t1_done_seen", 64'(ok), 64'h1);
    check_val("t1_cycles",    64'(cyc), 64'd20);
    check_val("t1_result",    result_a, {4{16'h4880}});
    check_val("t1_hs",        64'(hs_cnt - h0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("t1_a2d", 64'(log2d[h0 + i]), 64'(i / 2));
      check_val("t1_a1d", 64'(log1d[h0 + i]), 64'(i % 2));
    end
    tick(1);
    check_val("t1_pulse",  64'(conv_done_a), 64'h0);
    check_val("t1_idle",   64'(busy_a), 64'h0);
    check_val("t1_ndone",  64'(done_a), 64'd1);

    // 6a: conv_en still high -> no restart; stray res_valid in IDLE ignored
    tick(10);
    check_val("t6_norestart", 64'(busy_a), 64'h0);
    check_val("t6_ndone",     64'(done_a), 64'd1);
    stray_data = 16'hDEAD; stray_rv = 1'b1;
    tick(1);
    stray_rv = 1'b0;
    tick(1);
    check_val("t6_stray", result_a, {4{16'h4880}});

    // 6b: low then high -> new run, result cleared then rewritten
    conv_en = 1'b0; mac_base = 16'h1000; mac_step = 16'h1;
    tick(1);
    conv_en = 1'b1;
    tick(1);
    check_val("t6_busy",    64'(busy_a), 64'h1);
    check_val("t6_cleared", result_a, 64'h0);
    wait_done_a(100, ok, cyc);
    check_val("t6_done_seen", 64'(ok), 64'h1);
    check_val("t6_result",    result_a, {16'h1000, 16'h1001, 16'h1002, 16'h1003});

    // 2: 5x5 image, stride 2
    h0 = hs_b;
    conv_en_b = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (conv_done_b) begin ok = 1'b1; break; end
    end
    conv_en_b = 1'b0;
    check_val("t2_done_seen", 64'(ok), 64'h1);
    check_val("t2_hs",        64'(hs_b - h0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("t2_a2d", 64'(logb2d[h0 + i]), 64'((i / 2) * 2));
      check_val("t2_a1d", 64'(logb1d[h0 + i]), 64'((i % 2) * 2));
    end
    check_val("t2_result", result_b, {16'h3C00, 16'h3C01, 16'h3C02, 16'h3C03});

    // 3: backpressure in ISSUE
    conv_en = 1'b0; win_ready = 1'b0;
    tick(1);
    conv_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (win_valid_a) begin ok = 1'b1; break; end
    end
    check_val("t3_issue_seen", 64'(ok), 64'h1);
    h0 = hs_cnt;
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (!win_valid_a || archor_2D_a != 16'd0 || archor_1D_a != 16'd0) hold_ok = 1'b0;
    end
    check_val("t3_hold",   64'(hold_ok), 64'h1);
    check_val("t3_no_hs",  64'(hs_cnt - h0), 64'd0);
    win_ready = 1'b1;
    tick(1);
    check_val("t3_one_hs", 64'(hs_cnt - h0), 64'd1);
    check_val("t3_dropv",  64'(win_valid_a), 64'h0);
    wait_done_a(100, ok, cyc);
    check_val("t3_done_seen", 64'(ok), 64'h1);
    check_val("t3_hs_total",  64'(hs_cnt - h0), 64'd4);

    // 4: abort after slot 1 written
    conv_en = 1'b0; mac_base = 16'h2000;
    tick(1);
    conv_en = 1'b1;
    d0 = done_a;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s1 = result_a[16:31];
      if (s1 == 16'h2001) begin ok = 1'b1; break; end
    end
    check_val("t4_slot1_seen", 64'(ok), 64'h1);
    conv_en = 1'b0;
    tick(1);
    check_val("t4_busy",   64'(busy_a), 64'h0);
    check_val("t4_valid",  64'(win_valid_a), 64'h0);
    check_val("t4_result", result_a, {16'h2000, 16'h2001, 32'h0});
    tick(5);
    check_val("t4_nodone", 64'(done_a - d0), 64'd0);

    // 5: async reset in WAIT of the second window, then stray result in IDLE
    mac_base = 16'h3000;
    conv_en = 1'b1;
    h0 = hs_cnt;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (hs_cnt - h0 == 2) begin ok = 1'b1; break; end
    end
    check_val("t5_wait_seen", 64'(ok), 64'h1);
    check_val("t5_pre_slot0", result_a, {16'h3000, 48'h0});
    #1 reset = 1'b0;
    #1;
    check_val("t5_busy",   64'(busy_a), 64'h0);
    check_val("t5_valid",  64'(win_valid_a), 64'h0);
    check_val("t5_anchor", 64'({archor_2D_a, archor_1D_a}), 64'h0);
    check_val("t5_result", result_a, 64'h0);
    check_val("t5_done",   64'(conv_done_a), 64'h0);
    conv_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick(6);
    check_val("t5_stray_result", result_a, 64'h0);
    check_val("t5_stray_busy",   64'(busy_a), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
